// File: rtl/cpu_core_if.sv
// Execute/store control and register-observation bus of cpu_core.
// The driver (master) issues cs/we; the core (slave) returns R1..R4 and the store shadow.
interface cpu_core_if;
    logic       cs;
    logic       we;
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [7:0] reg3;
    logic [7:0] reg4;
    logic [7:0] reg5;

    modport master (output cs, we, input reg1, reg2, reg3, reg4, reg5);
    modport slave  (input cs, we, output reg1, reg2, reg3, reg4, reg5);
endinterface

// File: rtl/cpu_core.sv
// Single-cycle 8-bit register CPU: fixed 16-word ROM, R1..R4, 16x8 data memory, store shadow.
// Macro CPU_CORE_STORE_GATE_EN: when defined, ST only writes memory/shadow while we=1.
module cpu_core (
    input  logic     clk,
    input  logic     reset,
    cpu_core_if.slave bus
);

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDI = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_ST  = 4'd4
    } opcode_e;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [7:0] imm;   // rb lives in imm[7:6]
    } instr_t;

    function automatic logic [15:0] rom(input logic [3:0] addr);
        logic [15:0] w;
        case (addr)
            4'd0:    w = 16'h1002; // LDI R1,02
            4'd1:    w = 16'h1404; // LDI R2,04
            4'd2:    w = 16'h2040; // ADD R1,R1,R2
            4'd3:    w = 16'h1005; // LDI R1,05
            4'd4:    w = 16'h140E; // LDI R2,0E
            4'd5:    w = 16'h3040; // SUB R1,R1,R2
            4'd6:    w = 16'h4006; // ST  R1,[06]
            4'd7:    w = 16'h1403; // LDI R2,03
            4'd8:    w = 16'h2140; // ADD R1,R2,R2
            4'd9:    w = 16'h4004; // ST  R1,[04]
            4'd10:   w = 16'h180A; // LDI R3,0A
            4'd11:   w = 16'h1C0B; // LDI R4,0B
            4'd12:   w = 16'h3F80; // SUB R4,R4,R3
            4'd13:   w = 16'h4C0B; // ST  R4,[0B]
            4'd14:   w = 16'h180F; // LDI R3,0F
            4'd15:   w = 16'h480F; // ST  R3,[0F]
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    logic [3:0]        program_counter;
    logic [3:0]        pc_d;
    logic [3:0][7:0]   regs_q, regs_d;
    logic [15:0][7:0]  mem_q, mem_d;
    logic [7:0]        shadow_q, shadow_d;

    instr_t     ins;
    logic [1:0] rb;
    logic [7:0] a_val, b_val, d_val;
    logic       st_ok;

`ifdef CPU_CORE_STORE_GATE_EN
    assign st_ok = bus.we;
`else
    logic unused_we;
    assign unused_we = bus.we;
    assign st_ok     = 1'b1;
`endif

    assign ins   = instr_t'(rom(program_counter));
    assign rb    = ins.imm[7:6];
    assign a_val = regs_q[ins.ra];
    assign b_val = regs_q[rb];
    assign d_val = regs_q[ins.rd];

    // Sources come from the _q copies, so rd may alias ra/rb safely.
    always_comb begin
        pc_d     = program_counter;
        regs_d   = regs_q;
        mem_d    = mem_q;
        shadow_d = shadow_q;
        if (bus.cs) begin
            pc_d = program_counter + 4'd1;
            case (opcode_e'(ins.op))
                OP_LDI: regs_d[ins.rd] = ins.imm;
                OP_ADD: regs_d[ins.rd] = a_val + b_val;
                OP_SUB: regs_d[ins.rd] = a_val - b_val;
                OP_ST: begin
                    if (st_ok) begin
                        mem_d[ins.imm[3:0]] = d_val;
                        shadow_d            = d_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            program_counter <= '0;
            regs_q          <= '0;
            mem_q           <= '0;
            shadow_q        <= '0;
        end else begin
            program_counter <= pc_d;
            regs_q          <= regs_d;
            mem_q           <= mem_d;
            shadow_q        <= shadow_d;
        end
    end

    assign bus.reg1 = regs_q[0];
    assign bus.reg2 = regs_q[1];
    assign bus.reg3 = regs_q[2];
    assign bus.reg4 = regs_q[3];
    assign bus.reg5 = shadow_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: walks the fixed ROM program against hand-computed values.
module tb_cpu_core;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    cpu_core_if bus ();

    cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pc();
        return {4'h0, dut.program_counter};
    endfunction

    function automatic logic [7:0] mem(input int a);
        return dut.mem_q[a];
    endfunction

    task automatic chk_regs(input string tag, input logic [7:0] r1, input logic [7:0] r2,
                            input logic [7:0] r3, input logic [7:0] r4, input logic [7:0] r5);
        chk({tag, ".r1"}, bus.reg1, r1);
        chk({tag, ".r2"}, bus.reg2, r2);
        chk({tag, ".r3"}, bus.reg3, r3);
        chk({tag, ".r4"}, bus.reg4, r4);
        chk({tag, ".r5"}, bus.reg5, r5);
    endtask

    initial begin
        reset  = 1'b1;
        bus.cs = 1'b0;
        bus.we = 1'b0;
        step(5);
        chk("rst.pc", pc(), 8'h00);
        chk_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 16; i++) chk($sformatf("rst.mem%0d", i), mem(i), 8'h00);

        reset  = 1'b0;
        bus.cs = 1'b1;
        step(3);
        chk("run3.pc", pc(), 8'h03);
        chk("run3.r1", bus.reg1, 8'h06);
        chk("run3.r2", bus.reg2, 8'h04);

        step(3);
        chk("run6.pc", pc(), 8'h06);
        chk("run6.r1", bus.reg1, 8'hF7);
        chk("run6.r2", bus.reg2, 8'h0E);

        // stall across the ST; we toggling must not matter
        bus.cs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.we = i[0];
            step(1);
            chk($sformatf("stall%0d.pc", i), pc(), 8'h06);
            chk_regs($sformatf("stall%0d", i), 8'hF7, 8'h0E, 8'h00, 8'h00, 8'h00);
            chk($sformatf("stall%0d.mem6", i), mem(6), 8'h00);
        end

        // ST at PC=6 with we=0
        bus.cs = 1'b1;
        bus.we = 1'b0;
        step(1);
        chk("stwe0.pc", pc(), 8'h07);
`ifdef CPU_CORE_STORE_GATE_EN
        chk("stwe0.mem6", mem(6), 8'h00);
        chk("stwe0.r5", bus.reg5, 8'h00);
`else
        chk("stwe0.mem6", mem(6), 8'hF7);
        chk("stwe0.r5", bus.reg5, 8'hF7);
`endif

        // full program from reset with we=1
        reset  = 1'b1;
        bus.cs = 1'b0;
        step(1);
        reset  = 1'b0;
        bus.cs = 1'b1;
        bus.we = 1'b1;
        step(7);
        chk("full7.pc", pc(), 8'h07);
        chk("full7.mem6", mem(6), 8'hF7);
        chk("full7.r5", bus.reg5, 8'hF7);
        step(9);
        chk("full.pc", pc(), 8'h00);
        chk_regs("full", 8'h06, 8'h03, 8'h0F, 8'h01, 8'h0F);
        chk("full.mem4", mem(4), 8'h06);
        chk("full.mem6", mem(6), 8'hF7);
        chk("full.mem11", mem(11), 8'h01);
        chk("full.mem15", mem(15), 8'h0F);

        // second pass up to PC=10: registers carried over, then re-derived by the program
        step(10);
        chk("pass2.pc", pc(), 8'h0A);
        chk_regs("pass2", 8'h06, 8'h03, 8'h0F, 8'h01, 8'h06);

        // reset mid-program with cs=1 takes priority
        reset = 1'b1;
        step(1);
        chk("mrst.pc", pc(), 8'h00);
        chk_regs("mrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("mrst.mem4", mem(4), 8'h00);
        chk("mrst.mem6", mem(6), 8'h00);
        chk("mrst.mem15", mem(15), 8'h00);

        reset  = 1'b0;
        bus.cs = 1'b0;
        step(1);
        chk("idle.pc", pc(), 8'h00);
        bus.cs = 1'b1;
        step(1);
        chk("resume.pc", pc(), 8'h01);
        chk("resume.r1", bus.reg1, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
# cpu_core

Single-cycle 8-bit accumulator-free register CPU with a fixed 16-entry instruction ROM, four general-purpose registers, a 16×8 data memory and a store-shadow register. It executes one instruction per enabled clock and exposes its register file for observation; it is the top-level compute block of the CPU-RTL design.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- cs  input  1  execute enable; 1 = execute instruction at PC this cycle, 0 = stall.
- we  input  1  store write enable; gates data-memory writes (see Configuration).
- reg1  output  8  register R1.
- reg2  output  8  register R2.
- reg3  output  8  register R3.
- reg4  output  8  register R4.
- reg5  output  8  store shadow: last data byte written to data memory.

Internal signal `program_counter` (4 bits) keeps this exact name; benches probe it hierarchically.

## Operation
- Instruction word 16 bits: op[15:12], rd[11:10], ra[9:8], rb[7:6], imm[7:0] (rb overlaps imm; unused fields ignored). Register index 0..3 = R1..R4.
- Opcodes: 0 NOP; 1 LDI rd ← imm; 2 ADD rd ← ra + rb; 3 SUB rd ← ra − rb; 4 ST mem[imm[3:0]] ← rd, reg5 ← rd; 5–15 treated as NOP.
- Arithmetic mod 256, no flags, no carry/borrow kept; rd may equal ra/rb (sources read before write).
- Fixed ROM program, addresses 0–15: LDI R1,02; LDI R2,04; ADD R1,R1,R2; LDI R1,05; LDI R2,0E; SUB R1,R1,R2; ST R1,[06]; LDI R2,03; ADD R1,R2,R2; ST R1,[04]; LDI R3,0A; LDI R4,0B; SUB R4,R4,R3; ST R4,[0B]; LDI R3,0F; ST R3,[0F].
- Data memory: 16×8, internal only, write-only from the ISA.

## Timing
- Reset (sampled on rising edge, priority over cs/we): PC=0, R1–R4=00, reg5=00, all data memory=00.
- cs=1: ROM[PC] executes in that cycle; register/memory/reg5 results and PC+1 visible after the same edge (latency 1 clock, one instruction per cycle).
- cs=0: PC, registers, memory, reg5 hold; we ignored.
- PC wraps 15 → 0; program re-executes from address 0 with current register contents.
- Outputs are registered; no combinational path from inputs to reg1–reg5.
- reset asserted mid-program: all state cleared at that edge; execution resumes at PC=0 on the first cs=1 edge after reset deasserts.

## Configuration
- Macro CPU_CORE_STORE_GATE_EN.
- Defined: ST writes memory and reg5 only if we=1 in the executing cycle; with we=0 the ST retires (PC advances) with no memory/reg5 change.
- Undefined: ST always writes memory and reg5; we is ignored entirely.

## Test plan
- Reset 5 cycles, then cs=1 for 3 cycles -> R1=06, R2=04, PC=3.
- Continue cs=1 through PC=6 -> R1=F7 (05−0E), R2=0E; at ST (macro defined, we=1) mem[6]=F7, reg5=F7.
- Toggle cs=0 for 4 cycles mid-program -> PC and reg1–reg5 unchanged throughout.
- Run full program with we=1 -> final R1=06, R2=03, R3=0F, R4=01, mem[4]=06, mem[0B]=01, mem[0F]=0F, reg5=0F, PC wraps to 0.
- Macro defined, we=0 during ST at PC=6 -> mem[6]=00, reg5 unchanged, PC=7; macro undefined, same stimulus -> mem[6]=F7.
- Assert reset at PC=10 with cs=1 -> next edge PC=0, all registers 00, memory cleared.
